// File: rtl/boot_pkg.sv
// Shared constants and state encoding for the byte-stream program loader.
package boot_pkg;
    localparam logic [7:0] CMD_IMEM = 8'h49;
    localparam logic [7:0] CMD_DMEM = 8'h44;
    localparam logic [7:0] CMD_GO   = 8'h47;

    localparam int HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_RUN,
        ST_ERR
    } state_e;
endpackage

// File: rtl/boot_loader.sv
// Framed byte-stream loader: parses CMD/ADDR/LEN frames, writes bytes into
// imem or dmem, and holds the core in reset until a GO command arrives.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024,
    parameter int TIMEOUT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W+1)'(IMEM_BYTES);
    localparam logic [ADDR_W:0] DMEM_LIM = (ADDR_W+1)'(DMEM_BYTES);
    localparam logic [31:0]     WD_LIM   = 32'(TIMEOUT);

    state_e            state_q, state_d;
    logic [1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [23:0]       hdr_q, hdr_d;
    logic              tgt_i_q, tgt_i_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wd_q, wd_d;

    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [31:0]       hdr_full;
    logic [ADDR_W-1:0] hdr_base, hdr_len, idx_inc;
    logic [ADDR_W:0]   hdr_end, hdr_lim;

    assign accept   = in_valid && in_ready_q;
    // The last header byte is still on in_data when the frame is decided.
    assign hdr_full = {hdr_q, in_data};
    assign hdr_base = hdr_full[16 +: ADDR_W];
    assign hdr_len  = hdr_full[0 +: ADDR_W];
    assign hdr_end  = {1'b0, hdr_base} + {1'b0, hdr_len};
    assign hdr_lim  = tgt_i_q ? IMEM_LIM : DMEM_LIM;
    assign idx_inc  = idx_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        hdr_d       = hdr_q;
        tgt_i_d     = tgt_i_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_rst_d  = core_rst_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: if (accept) begin
                hdr_cnt_d = '0;
                if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
                    tgt_i_d = (in_data == CMD_IMEM);
                    state_d = ST_HDR;
                end else if (in_data == CMD_GO) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
            end
            ST_HDR: if (accept) begin
                if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
                    base_d = hdr_base;
                    len_d  = hdr_len;
                    idx_d  = '0;
                    wd_d   = '0;
                    if (hdr_end > hdr_lim) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (hdr_len == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    hdr_d     = {hdr_q[15:0], in_data};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    imem_we_d   = tgt_i_q;
                    dmem_we_d   = !tgt_i_q;
                    mem_addr_d  = base_q + idx_q;
                    mem_wdata_d = in_data;
                    idx_d       = idx_inc;
                    wd_d        = '0;
                    if (idx_inc == len_q) state_d = ST_IDLE;
                end else if (TIMEOUT != 0) begin
                    wd_d = wd_q + 32'd1;
                    if (wd_d == WD_LIM) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: ;  // RUN and ERR hold until reset
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_HDR) || (state_d == ST_DATA);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= '0;
            hdr_q       <= '0;
            tgt_i_q     <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            in_ready_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_q       <= hdr_d;
            tgt_i_q     <= tgt_i_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            in_ready_q  <= in_ready_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign imem_we   = imem_we_q;
    assign dmem_we   = dmem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frames driven at negedge, strobes logged at negedge.
module tb_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_we, dmem_we, core_rst, done, err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    boot_loader #(.ADDR_W(16), .IMEM_BYTES(1024), .DMEM_BYTES(1024), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nerr = 0;
    int acc_q[$];
    int w_cyc[$];
    logic [15:0] w_addr[$];
    logic [7:0]  w_data[$];
    bit   w_isi[$];
    int both_hi = 0, crl = 0;

    always @(negedge clk) begin
        if (imem_we || dmem_we) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(mem_addr);
            w_data.push_back(mem_wdata);
            w_isi.push_back(imem_we);
        end
        if (imem_we && dmem_we) both_hi++;
        if (!core_rst) crl++;
    end

    task automatic clear_log();
        acc_q.delete(); w_cyc.delete(); w_addr.delete(); w_data.delete(); w_isi.delete();
        both_hi = 0; crl = 0;
    endtask

    // Present one byte for one cycle; in_valid stays high until idle() is called.
    task automatic send(input logic [7:0] b, input bit is_data);
        in_valid = 1'b1;
        in_data  = b;
        if (is_data) acc_q.push_back(cyc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] c, input logic [15:0] a, input logic [15:0] l);
        logic [15:0] av, lv;
        av = a; lv = l;
        send(c, 0); send(av[15:8], 0); send(av[7:0], 0); send(lv[15:8], 0); send(lv[7:0], 0);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h47;
        repeat (3) @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        nvec++; if ({imem_we, dmem_we} !== 2'b00) begin nerr++; $display("FAIL reset we: got %b want 00", {imem_we, dmem_we}); end
        nvec++; if (mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin nerr++; $display("FAIL reset addr/data: got %h/%h want 0000/00", mem_addr, mem_wdata); end
        nvec++; if ({core_rst, done, err} !== 3'b100) begin nerr++; $display("FAIL reset core_rst/done/err: got %b want 100", {core_rst, done, err}); end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset release in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_load_program();
        logic [7:0] prog [24];
        prog = '{8'h8C, 8'h80, 8'h00, 8'h00, 8'h8C, 8'h81, 8'h00, 8'h04,
                 8'h00, 8'h01, 8'h10, 8'h20, 8'hAC, 8'h82, 8'h00, 8'h08,
                 8'h10, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset(); clear_log();
        send_hdr(8'h49, 16'h0000, 16'h0018);
        for (int i = 0; i < 24; i++) send(prog[i], 1);
        nvec++; if ({core_rst, done} !== 2'b10) begin nerr++; $display("FAIL prog pre-go core_rst/done: got %b want 10", {core_rst, done}); end
        send(8'h47, 0);
        nvec++; if ({core_rst, done} !== 2'b01) begin nerr++; $display("FAIL prog go+1 core_rst/done: got %b want 01", {core_rst, done}); end
        idle(3);
        nvec++; if (w_cyc.size() != 24) begin nerr++; $display("FAIL prog write count: got %0d want 24", w_cyc.size()); end
        for (int i = 0; i < 24 && i < w_cyc.size(); i++) begin
            nvec++;
            if (w_addr[i] !== 16'(i) || w_data[i] !== prog[i] || w_isi[i] !== 1'b1 || w_cyc[i] != acc_q[i] + 1) begin
                nerr++;
                $display("FAIL prog write %0d: got addr %h data %h imem %b cyc %0d want %h %h 1 %0d",
                         i, w_addr[i], w_data[i], w_isi[i], w_cyc[i], 16'(i), prog[i], acc_q[i] + 1);
            end
        end
        nvec++; if (both_hi != 0) begin nerr++; $display("FAIL prog both strobes: got %0d want 0", both_hi); end
        nvec++; if ({in_ready, core_rst, done, err} !== 4'b0010) begin nerr++; $display("FAIL prog run state rdy/crst/done/err: got %b want 0010", {in_ready, core_rst, done, err}); end
    endtask

    task automatic test_dmem_toggle();
        logic [7:0] d [4];
        d = '{8'h00, 8'h00, 8'h00, 8'h01};
        do_reset(); clear_log();
        send_hdr(8'h44, 16'h0004, 16'h0004);
        for (int i = 0; i < 4; i++) begin send(d[i], 1); idle(1); end
        idle(2);
        nvec++; if (w_cyc.size() != 4) begin nerr++; $display("FAIL dmem write count: got %0d want 4", w_cyc.size()); end
        for (int i = 0; i < 4 && i < w_cyc.size(); i++) begin
            nvec++;
            if (w_addr[i] !== 16'(4 + i) || w_data[i] !== d[i] || w_isi[i] !== 1'b0 || w_cyc[i] != acc_q[i] + 1) begin
                nerr++;
                $display("FAIL dmem write %0d: got addr %h data %h imem %b cyc %0d want %h %h 0 %0d",
                         i, w_addr[i], w_data[i], w_isi[i], w_cyc[i], 16'(4 + i), d[i], acc_q[i] + 1);
            end
        end
        nvec++; if ({in_ready, core_rst, err} !== 3'b110) begin nerr++; $display("FAIL dmem idle rdy/crst/err: got %b want 110", {in_ready, core_rst, err}); end
    endtask

    task automatic test_bad_cmd();
        do_reset(); clear_log();
        send(8'h55, 0);
        nvec++; if ({err, in_ready, core_rst, done} !== 4'b1010) begin nerr++; $display("FAIL badcmd err/rdy/crst/done: got %b want 1010", {err, in_ready, core_rst, done}); end
        send_hdr(8'h49, 16'h0000, 16'h0001);
        send(8'hAB, 0); send(8'h47, 0);
        idle(2);
        nvec++; if (w_cyc.size() != 0) begin nerr++; $display("FAIL badcmd writes: got %0d want 0", w_cyc.size()); end
        nvec++; if ({err, core_rst, done} !== 3'b110) begin nerr++; $display("FAIL badcmd sticky err/crst/done: got %b want 110", {err, core_rst, done}); end
    endtask

    task automatic test_bounds();
        do_reset(); clear_log();
        send_hdr(8'h49, 16'h03FE, 16'h0004);
        nvec++; if ({err, in_ready} !== 2'b10) begin nerr++; $display("FAIL bounds over err/rdy: got %b want 10", {err, in_ready}); end
        for (int i = 0; i < 4; i++) send(8'h5A, 0);
        idle(2);
        nvec++; if (w_cyc.size() != 0) begin nerr++; $display("FAIL bounds over writes: got %0d want 0", w_cyc.size()); end
        // exactly filling the last word is legal
        do_reset(); clear_log();
        send_hdr(8'h49, 16'h03FC, 16'h0004);
        for (int i = 0; i < 4; i++) send(8'(8'h11 * (i + 1)), 1);
        idle(2);
        nvec++; if (err !== 1'b0 || w_cyc.size() != 4) begin nerr++; $display("FAIL bounds edge err/count: got %b/%0d want 0/4", err, w_cyc.size()); end
        if (w_cyc.size() == 4) begin
            nvec++; if (w_addr[3] !== 16'h03FF || w_data[3] !== 8'h44) begin nerr++; $display("FAIL bounds edge last: got %h/%h want 03ff/44", w_addr[3], w_data[3]); end
        end
        send_hdr(8'h44, 16'h0000, 16'h0000);
        idle(2);
        nvec++; if ({err, in_ready} !== 2'b01 || w_cyc.size() != 4) begin nerr++; $display("FAIL zero len err/rdy/count: got %b/%0d want 01/4", {err, in_ready}, w_cyc.size()); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset(); clear_log();
        send_hdr(8'h49, 16'h0010, 16'h0008);
        send(8'h01, 1); send(8'h02, 1);
        do_reset();
        nvec++; if (w_cyc.size() != 2) begin nerr++; $display("FAIL midrst writes before: got %0d want 2", w_cyc.size()); end
        send_hdr(8'h44, 16'h0000, 16'h0001);
        send(8'hAA, 1);
        idle(2);
        nvec++; if (w_cyc.size() != 3) begin nerr++; $display("FAIL midrst total writes: got %0d want 3", w_cyc.size()); end
        if (w_cyc.size() == 3) begin
            nvec++;
            if (w_addr[1] !== 16'h0011 || w_data[1] !== 8'h02 || w_isi[1] !== 1'b1) begin
                nerr++; $display("FAIL midrst pre write: got %h/%h/%b want 0011/02/1", w_addr[1], w_data[1], w_isi[1]);
            end
            nvec++;
            if (w_addr[2] !== 16'h0000 || w_data[2] !== 8'hAA || w_isi[2] !== 1'b0 || w_cyc[2] != acc_q[2] + 1) begin
                nerr++; $display("FAIL midrst new write: got %h/%h/%b cyc %0d want 0000/aa/0 %0d", w_addr[2], w_data[2], w_isi[2], w_cyc[2], acc_q[2] + 1);
            end
        end
        nvec++; if (crl != 0) begin nerr++; $display("FAIL midrst core_rst low cycles: got %0d want 0", crl); end
    endtask

    task automatic test_timeout();
        do_reset(); clear_log();
        send_hdr(8'h49, 16'h0000, 16'h0002);
        send(8'h11, 1);
        idle(7);
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL timeout 7 idle err: got %b want 0", err); end
        idle(1);
        nvec++; if ({err, in_ready} !== 2'b10) begin nerr++; $display("FAIL timeout 8 idle err/rdy: got %b want 10", {err, in_ready}); end
        send(8'h22, 1);
        idle(2);
        nvec++; if (w_cyc.size() != 1) begin nerr++; $display("FAIL timeout writes: got %0d want 1", w_cyc.size()); end
        do_reset(); clear_log();
        send_hdr(8'h49, 16'h0000, 16'h0002);
        send(8'h11, 1);
        idle(7);
        send(8'h22, 1);
        idle(10);
        nvec++; if ({err, in_ready} !== 2'b01 || w_cyc.size() != 2) begin nerr++; $display("FAIL timeout recover err/rdy/count: got %b/%0d want 01/2", {err, in_ready}, w_cyc.size()); end
        if (w_cyc.size() == 2) begin
            nvec++; if (w_addr[1] !== 16'h0001 || w_data[1] !== 8'h22) begin nerr++; $display("FAIL timeout second write: got %h/%h want 0001/22", w_addr[1], w_data[1]); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_program();
        test_dmem_toggle();
        test_bad_cmd();
        test_bounds();
        test_reset_mid_frame();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
